// File: rtl/vtc_cfg.sv
// Runtime-configurable video timing controller: shadowed, validated timing that is
// committed only at a frame wrap (or while disabled), with registered HS/VS/DE/x/y/markers.
module vtc_cfg #(
  parameter int CNT_W            = 12,
  parameter bit HS_POL           = 1'b1,
  parameter bit VS_POL           = 1'b1,
  parameter int DEF_H_ACTIVE     = 1280,
  parameter int DEF_H_TOTAL      = 1650,
  parameter int DEF_H_SYNC_START = 1390,
  parameter int DEF_H_SYNC_END   = 1430,
  parameter int DEF_V_ACTIVE     = 720,
  parameter int DEF_V_TOTAL      = 750,
  parameter int DEF_V_SYNC_START = 725,
  parameter int DEF_V_SYNC_END   = 730
) (
  input  logic             vtc_clk_i,
  input  logic             vtc_rstn_i,
  input  logic             vtc_en_i,
  input  logic [CNT_W-1:0] cfg_h_active_i,
  input  logic [CNT_W-1:0] cfg_h_total_i,
  input  logic [CNT_W-1:0] cfg_h_sync_start_i,
  input  logic [CNT_W-1:0] cfg_h_sync_end_i,
  input  logic [CNT_W-1:0] cfg_v_active_i,
  input  logic [CNT_W-1:0] cfg_v_total_i,
  input  logic [CNT_W-1:0] cfg_v_sync_start_i,
  input  logic [CNT_W-1:0] cfg_v_sync_end_i,
  input  logic             cfg_update_i,
  output logic             cfg_pending_o,
  output logic             cfg_err_o,
  output logic             vtc_hs_o,
  output logic             vtc_vs_o,
  output logic             vtc_de_o,
  output logic [CNT_W-1:0] vtc_x_o,
  output logic [CNT_W-1:0] vtc_y_o,
  output logic             vtc_sof_o,
  output logic             vtc_eol_o
);

  typedef struct packed {
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] tot;
    logic [CNT_W-1:0] ss;
    logic [CNT_W-1:0] se;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } tim_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam tim_t DEF = '{
    h: '{act: CNT_W'(DEF_H_ACTIVE), tot: CNT_W'(DEF_H_TOTAL),
         ss:  CNT_W'(DEF_H_SYNC_START), se: CNT_W'(DEF_H_SYNC_END)},
    v: '{act: CNT_W'(DEF_V_ACTIVE), tot: CNT_W'(DEF_V_TOTAL),
         ss:  CNT_W'(DEF_V_SYNC_START), se: CNT_W'(DEF_V_SYNC_END)}
  };

  function automatic logic axis_ok(input axis_t a);
    return (a.act != '0) && (a.act < a.tot) && (a.ss < a.se) &&
           (a.se <= a.tot) && (a.tot >= TWO);
  endfunction

  tim_t             cfg_in, shadow, work;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic             cfg_ok, h_last, v_last, commit;
  logic             de_raw, hs_raw, vs_raw;

  assign cfg_in = '{
    h: '{act: cfg_h_active_i, tot: cfg_h_total_i, ss: cfg_h_sync_start_i, se: cfg_h_sync_end_i},
    v: '{act: cfg_v_active_i, tot: cfg_v_total_i, ss: cfg_v_sync_start_i, se: cfg_v_sync_end_i}
  };

  assign cfg_ok = axis_ok(cfg_in.h) && axis_ok(cfg_in.v);
  assign h_last = (hcnt == work.h.tot - ONE);
  assign v_last = (vcnt == work.v.tot - ONE);
  // Disabled cycles count as frame boundaries, so pending timing lands before restart.
  assign commit = !vtc_en_i || (h_last && v_last);

  assign de_raw = (hcnt < work.h.act) && (vcnt < work.v.act);
  assign hs_raw = (hcnt >= work.h.ss) && (hcnt < work.h.se);
  assign vs_raw = (vcnt >= work.v.ss) && (vcnt < work.v.se);

  // Commit consumes the old shadow before a coincident update overwrites it.
  always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
    if (!vtc_rstn_i) begin
      work          <= DEF;
      shadow        <= DEF;
      cfg_pending_o <= 1'b0;
      cfg_err_o     <= 1'b0;
    end else begin
      if (commit) begin
        work          <= shadow;
        cfg_pending_o <= 1'b0;
      end
      if (cfg_update_i) begin
        if (cfg_ok) begin
          shadow        <= cfg_in;
          cfg_pending_o <= 1'b1;
          cfg_err_o     <= 1'b0;
        end else begin
          cfg_err_o     <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
    if (!vtc_rstn_i) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!vtc_en_i) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + ONE;
    end else begin
      hcnt <= hcnt + ONE;
    end
  end

  always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
    if (!vtc_rstn_i || !vtc_en_i) begin
      vtc_hs_o  <= ~HS_POL;
      vtc_vs_o  <= ~VS_POL;
      vtc_de_o  <= 1'b0;
      vtc_sof_o <= 1'b0;
      vtc_eol_o <= 1'b0;
      vtc_x_o   <= '0;
      vtc_y_o   <= '0;
    end else begin
      vtc_hs_o  <= hs_raw ~^ HS_POL;
      vtc_vs_o  <= vs_raw ~^ VS_POL;
      vtc_de_o  <= de_raw;
      vtc_sof_o <= de_raw && (hcnt == '0) && (vcnt == '0);
      vtc_eol_o <= de_raw && (hcnt == work.h.act - ONE);
      vtc_x_o   <= hcnt;
      vtc_y_o   <= vcnt;
    end
  end

endmodule

// File: doc/vtc_cfg.md
# vtc_cfg

Runtime-configurable video timing controller. It generates HS, VS, DE, pixel coordinates and frame/line markers for the display pipeline from a single pixel clock. Compared with the fixed-timing generator, timing is loaded through shadowed configuration inputs, committed only at a frame boundary, and validated before use. Sync polarity and counter width are parameters, and generation can be paused and restarted with an enable.

## Interface
- CNT_W, 12: width of all counters, config fields and coordinates
- HS_POL, 1: HS active level (1 = active-high)
- VS_POL, 1: VS active level
- DEF_H_ACTIVE / DEF_H_TOTAL / DEF_H_SYNC_START / DEF_H_SYNC_END, 1280 / 1650 / 1390 / 1430: reset horizontal timing
- DEF_V_ACTIVE / DEF_V_TOTAL / DEF_V_SYNC_START / DEF_V_SYNC_END, 720 / 750 / 725 / 730: reset vertical timing
---
- vtc_clk_i  in  1  pixel clock
- vtc_rstn_i  in  1  reset, asynchronous, active-low
- vtc_en_i  in  1  run enable
- cfg_h_active_i, cfg_h_total_i, cfg_h_sync_start_i, cfg_h_sync_end_i  in  CNT_W each  staged horizontal timing
- cfg_v_active_i, cfg_v_total_i, cfg_v_sync_start_i, cfg_v_sync_end_i  in  CNT_W each  staged vertical timing
- cfg_update_i  in  1  single-cycle pulse that samples all cfg_* inputs
- cfg_pending_o  out  1  sampled config is waiting to be committed
- cfg_err_o  out  1  last update was rejected (sticky)
- vtc_hs_o, vtc_vs_o, vtc_de_o  out  1  timing outputs
- vtc_x_o, vtc_y_o  out  CNT_W  pixel coordinates; meaningful only while vtc_de_o = 1
- vtc_sof_o  out  1  pulse with pixel (0,0)
- vtc_eol_o  out  1  pulse with the last active pixel of each active line

## Operation
- **Counters.** hcnt runs 0..h_total-1. vcnt advances when hcnt = h_total-1 and wraps from v_total-1 to 0.
- **Sync windows.**
  - HS raw is active for h_sync_start ≤ hcnt < h_sync_end.
  - VS raw is active for v_sync_start ≤ vcnt < v_sync_end.
  - DE is active for hcnt < h_active and vcnt < v_active.
- **Polarity.** vtc_hs_o = HS raw XNOR HS_POL. VS is handled the same way with VS_POL.
- **Markers.**
  - sof: DE active and hcnt = 0 and vcnt = 0.
  - eol: DE active and hcnt = h_active-1.
- **Validation on cfg_update_i.** The sampled config is valid only if all of the following hold:
  - 0 < active < total
  - sync_start < sync_end ≤ total
  - total ≥ 2
  - all checks apply to both the horizontal and vertical axes
- **Valid update.** Load the shadow registers, set cfg_pending_o, clear cfg_err_o.
- **Invalid update.** Leave the shadow and pending state unchanged, set cfg_err_o.
- **Commit.** The shadow is copied to the working timing registers, and cfg_pending_o clears, in the same cycle the counters wrap to (0,0). This happens either at hcnt = h_total-1 with vcnt = v_total-1, or in any cycle vtc_en_i = 0. The working timing therefore never changes mid-frame.
- **Update during the commit cycle.** If cfg_update_i coincides with a commit cycle, the old shadow is committed. The new sample is stored and stays pending until the next commit.
- **Enable low.**
  - Counters are forced to 0 on the next edge.
  - Registered outputs go inactive: DE 0, HS/VS at their inactive level, markers 0, x/y 0.
  - When vtc_en_i rises, generation starts at hcnt = vcnt = 0.

## Timing
- All outputs are registered, with exactly one cycle latency from counter state. When the counters hold (h, v), the outputs on the next cycle reflect (h, v), with vtc_x_o = h and vtc_y_o = v.
- Output values during reset:
  - vtc_hs_o = ~HS_POL, vtc_vs_o = ~VS_POL.
  - vtc_de_o, vtc_sof_o, vtc_eol_o, cfg_pending_o, cfg_err_o = 0.
  - vtc_x_o, vtc_y_o = 0.
  - Working and shadow timing = DEF_* values.
- Reset release: the first counter state is (0,0) on the first edge with vtc_rstn_i high and vtc_en_i high.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously), and any pending config is discarded.
- Per-line periods:
  - HS active exactly h_sync_end − h_sync_start cycles per line.
  - VS active exactly (v_sync_end − v_sync_start) × h_total cycles per frame.
  - DE high h_active cycles per active line.

## Test plan
- **Reset and defaults.** With defaults, hold reset, then enable. Require every output at its reset value during reset. Require the first vtc_sof_o 1 cycle after enable with x = 0, y = 0, and 1650 × 750 cycles between consecutive sof pulses.
- **Default frame counts.** Over one frame require:
  - 921600 DE cycles.
  - 720 eol pulses, each with x = 1279.
  - HS high 40 cycles, first at x-position 1390.
  - VS active for 5 lines starting at line 725.
- **Mid-frame update.** Pulse cfg_update_i mid-frame with h_total = 800, h_active = 640, sync 656/752, v_total = 525, v_active = 480, sync 490/492. Require:
  - cfg_pending_o = 1 until the frame wrap.
  - The current frame keeps 1650 × 750 timing.
  - The next frame has an 800-cycle line, 640 DE cycles per line, and 480 active lines.
- **Rejected update.** Update with h_sync_end = 1700 > h_total = 1650. Require cfg_err_o = 1, cfg_pending_o unchanged, and timing unchanged. A following valid update clears cfg_err_o.
- **Enable drop.** Drop vtc_en_i at hcnt = 500, vcnt = 300. Require:
  - Outputs inactive 1 cycle later.
  - Any pending config committed.
  - On re-enable, sof fires 1 cycle after the first enabled edge.
- **Polarity.** With HS_POL = 0 and VS_POL = 0, require vtc_hs_o low for exactly 40 cycles per line, vtc_vs_o low for exactly 5 lines, and both high during reset.
